// File: rtl/bus_timer_slave.sv
// -----------------------------------------------------------------------------
// bus_timer_slave
//
// Programmable interval timer attached to one slave port of the peripheral
// bus switch. A 32-bit down-counter is advanced by a prescaled tick. The timer
// runs either one-shot or auto-reload, latches an expiry flag and drives a
// level interrupt to the CPU.
//
// Register map (adr_i[3:2]):
//   0 CTRL   [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN (other bits read 0)
//   1 LOAD   reload value, R/W; a write also loads COUNT and restarts the prescaler
//   2 COUNT  current count, read-only (writes acked and ignored)
//   3 STATUS [0] EXPIRED, write 1 to clear
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active low
//   stb_i    strobe from switch
//   cyc_i    bus cycle valid from switch
//   we_i     1 = write, 0 = read
//   adr_i    byte address; only adr_i[3:2] decoded
//   dat_i    write data
//   sel_i    byte enables; sel_i[k] gates dat_i[8k+7:8k]
//   dat_o    read data (register value before any write), 0 while ack_o=0
//   ack_o    single-cycle transfer acknowledge
//   irq_o    interrupt request, level, active high (EXPIRED & IRQ_EN)
//
// Handshake: a transfer is accepted at a rising edge where stb_i & cyc_i are
// high and ack_o is low. The write (if any) commits on that edge and ack_o
// plus dat_o are presented for exactly the following cycle. Because ack_o
// blocks acceptance, a strobe held high is acknowledged every second cycle.
// -----------------------------------------------------------------------------
module bus_timer_slave #(
   parameter int unsigned PRESCALE   = 50,
   parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stb_i,
   input  logic        cyc_i,
   input  logic        we_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        irq_o
);

   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_LOAD   = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   // Register state
   logic [2:0]    ctrl_q;       // {IRQ_EN, AUTO_RELOAD, EN}
   logic [31:0]   load_q;
   logic [31:0]   count_q;
   logic          expired_q;
   logic [PW-1:0] pre_cnt_q;
   logic          ack_q;
   logic [31:0]   dat_q;

   // Decode
   logic        accept;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_status;
   logic        status_clr;
   logic [31:0] load_new;
   logic [31:0] rd_data;

   // Timer control
   logic en;
   logic auto_reload;
   logic irq_en;
   logic tick;
   logic expire;

   // Only adr_i[3:2] selects a register; the rest of the address is ignored.
   logic unused_adr;
   assign unused_adr = ^{adr_i[31:4], adr_i[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) begin
         if (sel[k]) r[8*k +: 8] = new_v[8*k +: 8];
      end
      return r;
   endfunction

   assign en          = ctrl_q[0];
   assign auto_reload = ctrl_q[1];
   assign irq_en      = ctrl_q[2];

   assign accept     = stb_i & cyc_i & ~ack_q;
   assign wr_ctrl    = accept & we_i & (adr_i[3:2] == A_CTRL);
   assign wr_load    = accept & we_i & (adr_i[3:2] == A_LOAD);
   assign wr_status  = accept & we_i & (adr_i[3:2] == A_STATUS);
   assign status_clr = wr_status & sel_i[0] & dat_i[0];
   assign load_new   = merge_bytes(load_q, dat_i, sel_i);

   assign tick   = en & (pre_cnt_q == PRE_MAX);
   assign expire = tick & (count_q == 32'd0);

   // Read mux; dat_o captures this on accept, i.e. the value before the write.
   always_comb begin
      rd_data = 32'd0;
      case (adr_i[3:2])
         A_CTRL:   rd_data = {29'd0, ctrl_q};
         A_LOAD:   rd_data = load_q;
         A_COUNT:  rd_data = count_q;
         A_STATUS: rd_data = {31'd0, expired_q};
         default:  rd_data = 32'd0;
      endcase
   end

   // Bus response
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_q <= 1'b0;
         dat_q <= 32'd0;
      end else begin
         ack_q <= accept;
         dat_q <= accept ? rd_data : 32'd0;
      end
   end

   // Prescaler: free-runs 0..PRESCALE-1 while enabled, restarts on a LOAD write.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pre_cnt_q <= '0;
      end else if (wr_load || !en || tick) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_q + PW'(1);
      end
   end

   // CTRL: a bus write overrides the one-shot auto-disable in the same cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q <= 3'd0;
      end else if (wr_ctrl) begin
         if (sel_i[0]) ctrl_q <= dat_i[2:0];
      end else if (expire && !auto_reload) begin
         ctrl_q[0] <= 1'b0;
      end
   end

   // LOAD
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         load_q <= RESET_LOAD;
      end else if (wr_load) begin
         load_q <= load_new;
      end
   end

   // COUNT: a LOAD write wins over the tick; zero never decrements.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= RESET_LOAD;
      end else if (wr_load) begin
         count_q <= load_new;
      end else if (tick) begin
         if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
         end else if (auto_reload) begin
            count_q <= load_q;
         end
      end
   end

   // STATUS: expiry set wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         expired_q <= 1'b0;
      end else if (expire) begin
         expired_q <= 1'b1;
      end else if (status_clr) begin
         expired_q <= 1'b0;
      end
   end

   assign ack_o = ack_q;
   assign dat_o = dat_q;
   assign irq_o = expired_q & irq_en;

endmodule

// File: tb/tb_bus_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_timer_slave
//
// Directed bench for bus_timer_slave with PRESCALE=4. The driver pushes the
// hand-computed read data of every accepted transfer into exp_q; a monitor on
// the falling edge pops and compares whenever ack_o is high. Interrupt timing
// is checked at fixed cycle offsets from the accepting edge of the CTRL write.
// -----------------------------------------------------------------------------
module tb_bus_timer_slave;

  localparam int unsigned PRE = 4;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_LOAD   = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        stb, cyc, we;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        ack, irq;

  bus_timer_slave #(
    .PRESCALE   (PRE),
    .RESET_LOAD (32'hFFFF_FFFF)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .stb_i (stb),
    .cyc_i (cyc),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (wdat),
    .sel_i (sel),
    .dat_o (rdat),
    .ack_o (ack),
    .irq_o (irq)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        check("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack with dat %h, expected no transfer", rdat);
        end else begin
          check("rdata", rdat, exp_q.pop_front());
        end
      end else begin
        check("dat_idle_zero", rdat, 32'd0);
      end
    end
    ack_prev = ack;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; accepts on the next edge, returns one
  // idle cycle later (again just after a rising edge).
  task automatic xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, output logic irq_after);
    exp_q.push_back(exp);
    stb = 1'b1; cyc = 1'b1; we = w;
    adr = {28'h400_0001, r, 2'b00};
    wdat = d; sel = s;
    @(posedge clk); #1;
    check("ack_latency", {31'd0, ack}, 32'd1);
    irq_after = irq;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; wdat = 32'd0; sel = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp);
    logic dummy;
    xfer(1'b0, r, 32'd0, 4'd0, exp, dummy);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                    input logic [31:0] old_v);
    logic dummy;
    xfer(1'b1, r, d, s, old_v, dummy);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic irq_a;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'd0; wdat = 32'd0; sel = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(1);

    // 1. reset values
    rd(R_CTRL,   32'h0000_0000);
    rd(R_LOAD,   32'hFFFF_FFFF);
    rd(R_COUNT,  32'hFFFF_FFFF);
    rd(R_STATUS, 32'h0000_0000);

    // 4. byte-masked LOAD write; COUNT follows, COUNT itself not writable
    wr(R_LOAD, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF);
    rd(R_LOAD,  32'hFFFF_5678);
    rd(R_COUNT, 32'hFFFF_5678);
    wr(R_COUNT, 32'h0000_0000, 4'b1111, 32'hFFFF_5678);
    rd(R_COUNT, 32'hFFFF_5678);
    wr(R_CTRL, 32'hFFFF_FFF8, 4'b1111, 32'h0);     // only bits [2:0] exist
    rd(R_CTRL, 32'h0);

    // 2. auto-reload, LOAD=3: expiry 16 cycles after the CTRL accept edge E0
    wr(R_LOAD, 32'd3, 4'b1111, 32'hFFFF_5678);
    wr(R_CTRL, 32'h7, 4'b1111, 32'h0);              // returns at E1+1
    wait_cycles(14); check_irq("ar_irq_before", 1'b0);   // E15
    wait_cycles(1);  check_irq("ar_irq_at16",   1'b1);   // E16
    rd(R_COUNT, 32'd3);                             // accept E17, reloaded value
    wr(R_STATUS, 32'd1, 4'b0001, 32'd1);            // accept E19
    check_irq("ar_irq_cleared", 1'b0);              // E20+1
    wait_cycles(11); check_irq("ar_irq_before2", 1'b0);  // E31
    wait_cycles(1);  check_irq("ar_irq_at32",    1'b1);  // E32
    wr(R_CTRL,   32'h0, 4'b1111, 32'h7);
    wr(R_STATUS, 32'd1, 4'b0001, 32'd1);
    rd(R_STATUS, 32'd0);
    check_irq("ar_irq_off", 1'b0);

    // 3. one-shot, LOAD=2: expiry 12 cycles after accept edge F0, EN self-clears
    wr(R_LOAD, 32'd2, 4'b1111, 32'd3);
    wr(R_CTRL, 32'h5, 4'b1111, 32'h0);              // returns at F1+1
    wait_cycles(10); check_irq("os_irq_before", 1'b0);   // F11
    wait_cycles(1);  check_irq("os_irq_at12",   1'b1);   // F12
    rd(R_CTRL,  32'h4);
    rd(R_COUNT, 32'd0);
    wait_cycles(8);  check_irq("os_irq_held", 1'b1);
    rd(R_COUNT, 32'd0);
    wr(R_STATUS, 32'd0, 4'b0001, 32'd1);            // writing 0 has no effect
    rd(R_STATUS, 32'd1);
    xfer(1'b1, R_STATUS, 32'd1, 4'b0001, 32'd1, irq_a);
    check("os_irq_fall", {31'd0, irq_a}, 32'd0);
    rd(R_STATUS, 32'd0);

    // 5. clear in the same cycle as expiry: set wins
    wr(R_LOAD, 32'd3, 4'b1111, 32'd2);
    wr(R_CTRL, 32'h7, 4'b1111, 32'h4);              // accept H0, returns H1+1
    wait_cycles(14);                                // H15+1
    xfer(1'b1, R_STATUS, 32'd1, 4'b0001, 32'd0, irq_a);   // accept H16
    check("coll_irq_set_wins", {31'd0, irq_a}, 32'd1);
    rd(R_STATUS, 32'd1);                            // accept H18
    xfer(1'b1, R_STATUS, 32'd1, 4'b0001, 32'd1, irq_a);   // accept H20
    check("coll_irq_fall", {31'd0, irq_a}, 32'd0);
    check_irq("coll_irq_low", 1'b0);                // H21+1

    // 6. reset while ack is high and the timer is running
    wait_cycles(10); check_irq("rr_irq_before", 1'b0);   // H31
    wait_cycles(1);  check_irq("rr_irq_at32",   1'b1);   // H32
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {28'h0, R_COUNT, 2'b00};
    @(posedge clk); #1;                             // accept H33
    check("rr_ack", {31'd0, ack}, 32'd1);
    check("rr_dat", rdat, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rr_ack_reset", {31'd0, ack}, 32'd0);
    check("rr_dat_reset", rdat, 32'd0);
    check("rr_irq_reset", {31'd0, irq}, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_cycles(1);
    rd(R_CTRL,   32'h0000_0000);
    rd(R_LOAD,   32'hFFFF_FFFF);
    rd(R_COUNT,  32'hFFFF_FFFF);
    rd(R_STATUS, 32'h0000_0000);
    wait_cycles(12);
    rd(R_COUNT,  32'hFFFF_FFFF);                    // disabled timer does not count
    check_irq("rr_irq_after", 1'b0);

    // back-to-back strobe: acked every second cycle
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {28'h0, R_LOAD, 2'b00};
    @(posedge clk); #1; check("b2b_ack1", {31'd0, ack}, 32'd1);
    @(posedge clk); #1; check("b2b_gap",  {31'd0, ack}, 32'd0);
    @(posedge clk); #1; check("b2b_ack2", {31'd0, ack}, 32'd1);
    stb = 1'b0; cyc = 1'b0;
    wait_cycles(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
